// File: rtl/dec_ls_update_pkg.sv
// rtl/dec_ls_update_pkg.sv - shared types, opcodes and helpers for the update-form load/store decoder
package dec_ls_update_pkg;

    typedef enum logic [0:0] {S_MEM, S_ADDR} Dec_ls_state;

    typedef enum logic [2:0] {
        Alu_none, Alu_add, Alu_sub, Alu_and, Alu_or, Alu_xor
    } Alu_op;

    typedef enum logic [1:0] {Fu_none, Fu_alu, Fu_mul, Fu_spr} Fu_sel;

    typedef enum logic [2:0] {
        Ls_none, Load_byte, Load_halfword, Load_word,
        Store_byte, Store_halfword, Store_word
    } Ls_mode;

    typedef logic [4:0] Reg_idx;

    typedef struct packed {
        logic   alu_en;
        Alu_op  alu_op;
        Fu_sel  fxdp_sel;
        logic   ls_en;
        logic   ls_we;
        Ls_mode ls_mode;
        Reg_idx gpr_a;
        logic   read_gpr_a;
        Reg_idx gpr_b;
        logic   read_gpr_b;
        Reg_idx gpr_c;
        logic   read_gpr_c;
        Reg_idx gpr_from_alu;
        logic   write_gpr_from_alu;
        Reg_idx gpr_from_mem;
        logic   write_gpr_from_mem;
        logic   if_hold;
    } Control_word;

    localparam logic [5:0] Op_xform = 6'd31;
    localparam logic [5:0] Op_lwzu  = 6'd33;
    localparam logic [5:0] Op_lbzu  = 6'd35;
    localparam logic [5:0] Op_stwu  = 6'd37;
    localparam logic [5:0] Op_stbu  = 6'd39;
    localparam logic [5:0] Op_lhzu  = 6'd41;
    localparam logic [5:0] Op_sthu  = 6'd45;

    localparam logic [9:0] Xop_lwzux = 10'd55;
    localparam logic [9:0] Xop_lbzux = 10'd119;
    localparam logic [9:0] Xop_stwux = 10'd183;
    localparam logic [9:0] Xop_stbux = 10'd247;
    localparam logic [9:0] Xop_lhzux = 10'd311;
    localparam logic [9:0] Xop_sthux = 10'd439;

    localparam logic [1:0] Size_byte = 2'd0;
    localparam logic [1:0] Size_half = 2'd1;
    localparam logic [1:0] Size_word = 2'd2;

    function automatic Ls_mode ls_mode_of(input logic is_load, input logic [1:0] size);
        Ls_mode m;
        case (size)
            Size_byte: m = is_load ? Load_byte : Store_byte;
            Size_half: m = is_load ? Load_halfword : Store_halfword;
            default:   m = is_load ? Load_word : Store_word;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/Decode_ctrl_if.sv
// rtl/Decode_ctrl_if.sv - decode-stage pipeline control (hold)
interface Decode_ctrl_if;
    logic hold;
    modport decode (input hold);
    modport ctrl (output hold);
endinterface

// File: rtl/Decode_data_if.sv
// rtl/Decode_data_if.sv - instruction word presented to the decoders
interface Decode_data_if;
    logic [31:0] inst;
    modport decode (input inst);
    modport fetch (output inst);
endinterface

// File: rtl/dec_ls_update_match.sv
// rtl/dec_ls_update_match.sv - combinational classifier for the twelve update-form loads/stores
module dec_ls_update_match
    import dec_ls_update_pkg::*;
(
    input  logic [31:0] inst,
    output logic        active,
    output logic        is_load,
    output logic        is_indexed,
    output logic [1:0]  size
);

    logic [5:0] opcode;
    logic [9:0] xo;
    logic       unused_bits;

    assign opcode      = inst[31:26];
    assign xo          = inst[10:1];
    assign unused_bits = ^{inst[25:11], inst[0]};

    always_comb begin
        active     = 1'b0;
        is_load    = 1'b0;
        is_indexed = 1'b0;
        size       = Size_byte;
        case (opcode)
            Op_lbzu: begin active = 1'b1; is_load = 1'b1; size = Size_byte; end
            Op_lhzu: begin active = 1'b1; is_load = 1'b1; size = Size_half; end
            Op_lwzu: begin active = 1'b1; is_load = 1'b1; size = Size_word; end
            Op_stbu: begin active = 1'b1; size = Size_byte; end
            Op_sthu: begin active = 1'b1; size = Size_half; end
            Op_stwu: begin active = 1'b1; size = Size_word; end
            Op_xform: begin
                case (xo)
                    Xop_lbzux: begin active = 1'b1; is_indexed = 1'b1; is_load = 1'b1; size = Size_byte; end
                    Xop_lhzux: begin active = 1'b1; is_indexed = 1'b1; is_load = 1'b1; size = Size_half; end
                    Xop_lwzux: begin active = 1'b1; is_indexed = 1'b1; is_load = 1'b1; size = Size_word; end
                    Xop_stbux: begin active = 1'b1; is_indexed = 1'b1; size = Size_byte; end
                    Xop_sthux: begin active = 1'b1; is_indexed = 1'b1; size = Size_half; end
                    Xop_stwux: begin active = 1'b1; is_indexed = 1'b1; size = Size_word; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dec_ls_update.sv
// rtl/dec_ls_update.sv - update-form load/store decoder with memory-latency hold
// Optional illegal-RA detection: DEC_LS_UPDATE_INVALID_FORM_EN.
module dec_ls_update
    import dec_ls_update_pkg::*;
#(
    parameter int unsigned LS_CYCLES  = 2,
    parameter bit          MULTIPHASE = 1'b0
)(
    input  logic          clk,
    input  logic          reset,
    Decode_ctrl_if.decode ctrl,
    Decode_data_if.decode data,
    output Control_word   cw,
    output logic          busy,
    output logic          invalid_form
);

    localparam int CTR_W = (LS_CYCLES == 0) ? 1 : $clog2(LS_CYCLES + 1);
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(LS_CYCLES);

    logic             active;
    logic             is_load;
    logic             is_indexed;
    logic [1:0]       size;
    logic             bad_form;
    logic [CTR_W-1:0] ctr;
    logic [CTR_W-1:0] ctr_nxt;
    Dec_ls_state      state;
    Dec_ls_state      state_nxt;
    Reg_idx           rt;
    Reg_idx           ra;
    Reg_idx           rb;
    logic             unused_inst;

    assign rt          = data.inst[25:21];
    assign ra          = data.inst[20:16];
    assign rb          = data.inst[15:11];
    assign unused_inst = ^{data.inst[31:26], data.inst[10:0]};

    dec_ls_update_match u_match (
        .inst       (data.inst),
        .active     (active),
        .is_load    (is_load),
        .is_indexed (is_indexed),
        .size       (size)
    );

`ifdef DEC_LS_UPDATE_INVALID_FORM_EN
    assign bad_form = active && ((ra == 5'd0) || (is_load && (ra == rt)));
`else
    assign bad_form = 1'b0;
`endif
    assign invalid_form = bad_form;

    always_ff @(posedge clk) begin
        if (reset) ctr <= CTR_INIT;
        else       ctr <= ctr_nxt;
    end

    // Only the two-phase writeback ever leaves S_MEM.
    generate
        if (MULTIPHASE) begin : g_fsm
            always_ff @(posedge clk) begin
                if (reset) state <= S_MEM;
                else       state <= state_nxt;
            end
        end else begin : g_no_fsm
            logic unused_state;
            assign state        = S_MEM;
            assign unused_state = (state_nxt == S_ADDR);
        end
    endgenerate

    always_comb begin
        cw        = '0;
        busy      = 1'b0;
        ctr_nxt   = ctr;
        state_nxt = state;
        if (reset || !active) begin
            ctr_nxt   = CTR_INIT;
            state_nxt = S_MEM;
        end else begin
            cw.alu_en       = 1'b1;
            cw.ls_en        = 1'b1;
            cw.alu_op       = Alu_add;
            cw.fxdp_sel     = Fu_alu;
            cw.ls_mode      = ls_mode_of(is_load, size);
            cw.gpr_a        = ra;
            cw.read_gpr_a   = (ra != 5'd0);
            cw.gpr_b        = rb;
            cw.read_gpr_b   = is_indexed;
            cw.gpr_from_alu = ra;
            if (is_load) begin
                cw.gpr_from_mem = rt;
            end else begin
                cw.gpr_c      = rt;
                cw.read_gpr_c = 1'b1;
                cw.ls_we      = 1'b1;
            end

            if (bad_form) begin
                cw.ls_en = 1'b0;
            end else if (state == S_ADDR) begin
                cw.write_gpr_from_alu = 1'b1;
                if (!ctrl.hold) state_nxt = S_MEM;
            end else if (ctr != '0) begin
                cw.if_hold = 1'b1;
                busy       = 1'b1;
                if (!ctrl.hold) ctr_nxt = ctr - 1'b1;
            end else begin
                // Memory data is ready; a two-phase load defers the RA write one cycle.
                cw.write_gpr_from_mem = is_load;
                if (!ctrl.hold) ctr_nxt = CTR_INIT;
                if (MULTIPHASE && is_load) begin
                    cw.if_hold = 1'b1;
                    busy       = 1'b1;
                    if (!ctrl.hold) state_nxt = S_ADDR;
                end else begin
                    cw.write_gpr_from_alu = 1'b1;
                end
            end
        end
    end

endmodule
